// File: rtl/pop_sequence_monitor.sv
// Receive-side checker for the POP pulse train: times the pump/MW/probe phases and flags order/timeout errors.
// Optional build macro POPMON_OVERLAP_CHECK_EN additionally flags overlapping pump/MW/probe pulses.
module pop_sequence_monitor #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 65000
) (
    input  logic             clk_2M5,
    input  logic             reset,
    input  logic             enable,
    input  logic             err_clear,
    input  logic             pump,
    input  logic             probe,
    input  logic             MW,
    input  logic             sample,
    output logic [CNT_W-1:0] pump_width,
    output logic [CNT_W-1:0] pio2_1_width,
    output logic [CNT_W-1:0] free_precess,
    output logic [CNT_W-1:0] pio2_2_width,
    output logic [CNT_W-1:0] probe_width,
    output logic             meas_valid,
    output logic             seq_error,
    output logic [15:0]      cycle_count
);
    localparam int unsigned      CC_W      = 16;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_WAIT_PUMP  = 3'd0,
        ST_PUMP       = 3'd1,
        ST_DARK       = 3'd2,
        ST_MW1        = 3'd3,
        ST_FREE       = 3'd4,
        ST_MW2        = 3'd5,
        ST_WAIT_PROBE = 3'd6,
        ST_PROBE      = 3'd7
    } state_t;

    state_t           state, state_nxt;
    logic             s_pump, s_mw, s_probe;
    logic             d_pump, d_mw, d_probe;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] tmr, tmr_nxt;
    logic [CNT_W-1:0] stg_pump, stg_mw1, stg_free, stg_mw2, stg_probe;
    logic [CNT_W-1:0] stg_pump_nxt, stg_mw1_nxt, stg_free_nxt, stg_mw2_nxt, stg_probe_nxt;
    logic             commit_q, commit_nxt;
    logic             pump_rise_c, pump_fall_c, mw_rise_c, mw_fall_c, probe_rise_c, probe_fall_c;
    logic             order_err_c, timeout_c, overlap_c, err_new_c;
    logic             unused_sample;

    // sample is carried on the bus but deliberately not monitored
    assign unused_sample = sample;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Two-stage input registers: s_* is the measurement domain, d_* gives edges
    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            s_pump  <= 1'b0;
            s_mw    <= 1'b0;
            s_probe <= 1'b0;
            d_pump  <= 1'b0;
            d_mw    <= 1'b0;
            d_probe <= 1'b0;
        end else begin
            s_pump  <= pump;
            s_mw    <= MW;
            s_probe <= probe;
            d_pump  <= s_pump;
            d_mw    <= s_mw;
            d_probe <= s_probe;
        end
    end

    assign pump_rise_c  = s_pump & ~d_pump;
    assign pump_fall_c  = ~s_pump & d_pump;
    assign mw_rise_c    = s_mw & ~d_mw;
    assign mw_fall_c    = ~s_mw & d_mw;
    assign probe_rise_c = s_probe & ~d_probe;
    assign probe_fall_c = ~s_probe & d_probe;

`ifdef POPMON_OVERLAP_CHECK_EN
    assign overlap_c = (s_pump & s_mw) | (s_pump & s_probe) | (s_mw & s_probe);
`else
    assign overlap_c = 1'b0;
`endif

    // Phase sequencing, error detection and staging of widths
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        tmr_nxt       = tmr;
        stg_pump_nxt  = stg_pump;
        stg_mw1_nxt   = stg_mw1;
        stg_free_nxt  = stg_free;
        stg_mw2_nxt   = stg_mw2;
        stg_probe_nxt = stg_probe;
        commit_nxt    = 1'b0;
        order_err_c   = 1'b0;
        timeout_c     = 1'b0;
        err_new_c     = 1'b0;

        case (state)
            ST_WAIT_PUMP: begin
                order_err_c = probe_rise_c;
                if (pump_rise_c) begin
                    state_nxt = ST_PUMP;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_PUMP: begin
                order_err_c = mw_rise_c | probe_rise_c;
                if (pump_fall_c) begin
                    stg_pump_nxt = cnt;
                    state_nxt    = ST_DARK;
                end else if (s_pump) begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            ST_DARK: begin
                order_err_c = pump_rise_c | probe_rise_c;
                if (mw_rise_c) begin
                    state_nxt = ST_MW1;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_MW1: begin
                order_err_c = pump_rise_c | probe_rise_c;
                if (mw_fall_c) begin
                    stg_mw1_nxt = cnt;
                    state_nxt   = ST_FREE;
                    cnt_nxt     = CNT_ONE;
                end else if (s_mw) begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            ST_FREE: begin
                order_err_c = pump_rise_c | probe_rise_c;
                if (mw_rise_c) begin
                    stg_free_nxt = cnt;
                    state_nxt    = ST_MW2;
                    cnt_nxt      = CNT_ONE;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            ST_MW2: begin
                order_err_c = pump_rise_c | probe_rise_c;
                if (mw_fall_c) begin
                    stg_mw2_nxt = cnt;
                    state_nxt   = ST_WAIT_PROBE;
                end else if (s_mw) begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            ST_WAIT_PROBE: begin
                order_err_c = pump_rise_c | mw_rise_c;
                if (probe_rise_c) begin
                    state_nxt = ST_PROBE;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_PROBE: begin
                order_err_c = mw_rise_c;
                if (probe_fall_c) begin
                    stg_probe_nxt = cnt;
                    commit_nxt    = 1'b1;
                    if (pump_rise_c) begin
                        state_nxt = ST_PUMP;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        state_nxt = ST_WAIT_PUMP;
                    end
                end else if (s_probe) begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            default: state_nxt = ST_WAIT_PUMP;
        endcase

        // tmr counts cycles spent in the current state; a stay beyond TIMEOUT is a stall
        timeout_c = (state != ST_WAIT_PUMP) && (state_nxt == state) && (tmr >= TIMEOUT_V);
        if (state_nxt != state) begin
            tmr_nxt = (state_nxt == ST_WAIT_PUMP) ? '0 : CNT_ONE;
        end else begin
            tmr_nxt = (state == ST_WAIT_PUMP) ? '0 : sat_inc(tmr);
        end

        err_new_c = enable & (order_err_c | timeout_c | overlap_c);
        if (!enable || err_new_c) begin
            state_nxt  = ST_WAIT_PUMP;
            cnt_nxt    = '0;
            tmr_nxt    = '0;
            commit_nxt = 1'b0;
        end
    end

    // State, staging and published measurement registers
    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            state        <= ST_WAIT_PUMP;
            cnt          <= '0;
            tmr          <= '0;
            stg_pump     <= '0;
            stg_mw1      <= '0;
            stg_free     <= '0;
            stg_mw2      <= '0;
            stg_probe    <= '0;
            commit_q     <= 1'b0;
            pump_width   <= '0;
            pio2_1_width <= '0;
            free_precess <= '0;
            pio2_2_width <= '0;
            probe_width  <= '0;
            meas_valid   <= 1'b0;
            seq_error    <= 1'b0;
            cycle_count  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            tmr        <= tmr_nxt;
            stg_pump   <= stg_pump_nxt;
            stg_mw1    <= stg_mw1_nxt;
            stg_free   <= stg_free_nxt;
            stg_mw2    <= stg_mw2_nxt;
            stg_probe  <= stg_probe_nxt;
            commit_q   <= commit_nxt;
            meas_valid <= commit_q;
            if (commit_q) begin
                pump_width   <= stg_pump;
                pio2_1_width <= stg_mw1;
                free_precess <= stg_free;
                pio2_2_width <= stg_mw2;
                probe_width  <= stg_probe;
                cycle_count  <= cycle_count + CC_W'(1);
            end
            seq_error <= err_new_c | (seq_error & ~err_clear);
        end
    end

endmodule

// File: tb/tb_pop_sequence_monitor.sv
// Directed bench for pop_sequence_monitor: an event-timeline model predicts every output on every cycle.
module tb_pop_sequence_monitor;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 65000;

    logic             clk_2M5 = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b1;
    logic             err_clear = 1'b0;
    logic             pump = 1'b0;
    logic             probe = 1'b0;
    logic             MW = 1'b0;
    logic             sample = 1'b0;
    logic [CNT_W-1:0] pump_width, pio2_1_width, free_precess, pio2_2_width, probe_width;
    logic             meas_valid, seq_error;
    logic [15:0]      cycle_count;

    pop_sequence_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_2M5(clk_2M5), .reset(reset), .enable(enable), .err_clear(err_clear),
        .pump(pump), .probe(probe), .MW(MW), .sample(sample),
        .pump_width(pump_width), .pio2_1_width(pio2_1_width), .free_precess(free_precess),
        .pio2_2_width(pio2_2_width), .probe_width(probe_width),
        .meas_valid(meas_valid), .seq_error(seq_error), .cycle_count(cycle_count)
    );

    always #200 clk_2M5 = ~clk_2M5;

    typedef struct {
        int at;
        int pw;
        int m1;
        int fp;
        int m2;
        int prw;
    } meas_t;

    meas_t mq[$];
    int    eq[$];
    int    cq[$];
    int    cyc = 0;
    logic  rst_seen = 1'b0;
    int    checks = 0;
    int    failures = 0;
    int    m_pw = 0, m_m1 = 0, m_fp = 0, m_m2 = 0, m_prw = 0, m_cc = 0;
    logic  m_err = 1'b0;

    always @(posedge clk_2M5) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    // Each call holds a level for n sampled posedges
    task automatic drive(input logic p, input logic m, input logic pr, input int n);
        pump = p; MW = m; probe = pr; sample = pr;
        if (n > 0) begin
            repeat (n) @(posedge clk_2M5);
            #1;
        end
    endtask

    // A full POP cycle; the probe-low sample is at cyc+1, so the strobe lands at cyc+3
    task automatic run_seq(input int p, g1, m1, f, m2, g2, pr, tail);
        drive(1'b1, 1'b0, 1'b0, p);
        drive(1'b0, 1'b0, 1'b0, g1);
        drive(1'b0, 1'b1, 1'b0, m1);
        drive(1'b0, 1'b0, 1'b0, f);
        drive(1'b0, 1'b1, 1'b0, m2);
        drive(1'b0, 1'b0, 1'b0, g2);
        drive(1'b0, 1'b0, 1'b1, pr);
        mq.push_back('{at: cyc + 3, pw: p, m1: m1, fp: f, m2: m2, prw: pr});
        drive(1'b0, 1'b0, 1'b0, tail);
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        cq.push_back(cyc + 1);
        @(posedge clk_2M5);
        #1;
        err_clear = 1'b0;
    endtask

    // Model: apply the timeline events due this cycle, then compare all outputs
    always @(negedge clk_2M5) begin
        logic exp_mv, err_ev, clr_ev;
        exp_mv = 1'b0;
        err_ev = 1'b0;
        clr_ev = 1'b0;
        if (rst_seen) begin
            m_err = 1'b0; m_cc = 0;
            m_pw = 0; m_m1 = 0; m_fp = 0; m_m2 = 0; m_prw = 0;
        end else begin
            if (mq.size() != 0 && mq[0].at == cyc) begin
                exp_mv = 1'b1;
                m_pw = mq[0].pw; m_m1 = mq[0].m1; m_fp = mq[0].fp;
                m_m2 = mq[0].m2; m_prw = mq[0].prw;
                m_cc = (m_cc + 1) % 65536;
                void'(mq.pop_front());
            end
            if (eq.size() != 0 && eq[0] == cyc) begin
                err_ev = 1'b1;
                void'(eq.pop_front());
            end
            if (cq.size() != 0 && cq[0] == cyc) begin
                clr_ev = 1'b1;
                void'(cq.pop_front());
            end
            if (err_ev)      m_err = 1'b1;
            else if (clr_ev) m_err = 1'b0;
        end
        chk("meas_valid", 32'(meas_valid), 32'(exp_mv));
        chk("seq_error", 32'(seq_error), 32'(m_err));
        chk("cycle_count", 32'(cycle_count), 32'(m_cc));
        chk("pump_width", 32'(pump_width), 32'(m_pw));
        chk("pio2_1_width", 32'(pio2_1_width), 32'(m_m1));
        chk("free_precess", 32'(free_precess), 32'(m_fp));
        chk("pio2_2_width", 32'(pio2_2_width), 32'(m_m2));
        chk("probe_width", 32'(probe_width), 32'(m_prw));
    end

    initial begin
        repeat (3) @(posedge clk_2M5);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5);

        // Basic sequence
        run_seq(100, 20, 5, 50, 5, 10, 30, 10);
        chk("t1_pump_lit", 32'(pump_width), 32'd100);
        chk("t1_mw1_lit", 32'(pio2_1_width), 32'd5);
        chk("t1_free_lit", 32'(free_precess), 32'd50);
        chk("t1_mw2_lit", 32'(pio2_2_width), 32'd5);
        chk("t1_probe_lit", 32'(probe_width), 32'd30);
        chk("t1_count_lit", 32'(cycle_count), 32'd1);
        chk("t1_err_lit", 32'(seq_error), 32'd0);

        // Back-to-back: probe falls on the same sample pump rises
        run_seq(12, 3, 2, 7, 3, 2, 6, 0);
        run_seq(15, 4, 1, 9, 2, 3, 5, 0);
        run_seq(20, 2, 3, 4, 1, 1, 8, 10);
        chk("t2_count_lit", 32'(cycle_count), 32'd4);
        chk("t2_pump_lit", 32'(pump_width), 32'd20);

        // Probe rise during FREE, then a clean sequence, then error-vs-clear race
        drive(1'b1, 1'b0, 1'b0, 10);
        drive(1'b0, 1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 4);
        eq.push_back(cyc + 2);
        drive(1'b0, 1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 1'b0, 10);
        chk("t3_err_lit", 32'(seq_error), 32'd1);
        chk("t3_count_lit", 32'(cycle_count), 32'd4);
        run_seq(8, 2, 2, 6, 2, 2, 4, 5);
        chk("t3_clean_lit", 32'(free_precess), 32'd6);
        clear_err();
        drive(1'b0, 1'b0, 1'b0, 2);
        chk("t3_clear_lit", 32'(seq_error), 32'd0);
        eq.push_back(cyc + 2);
        drive(1'b0, 1'b0, 1'b1, 1);
        err_clear = 1'b1;
        cq.push_back(cyc + 1);
        drive(1'b0, 1'b0, 1'b0, 1);
        err_clear = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3);
        chk("t3_errwins_lit", 32'(seq_error), 32'd1);
        clear_err();
        drive(1'b0, 1'b0, 1'b0, 3);

        // Stalled pump: error after the 65001st high sample, widths held
        eq.push_back(cyc + 2 + int'(TIMEOUT));
        drive(1'b1, 1'b0, 1'b0, int'(TIMEOUT) + 5);
        drive(1'b0, 1'b0, 1'b0, 5);
        chk("t4_err_lit", 32'(seq_error), 32'd1);
        chk("t4_pump_lit", 32'(pump_width), 32'd8);
        clear_err();
        drive(1'b0, 1'b0, 1'b0, 3);

        // enable dropped inside MW2 discards the cycle silently
        drive(1'b1, 1'b0, 1'b0, 10);
        drive(1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 1'b0, 6);
        drive(1'b0, 1'b1, 1'b0, 2);
        enable = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b1, 4);
        drive(1'b0, 1'b0, 1'b0, 3);
        enable = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3);
        run_seq(9, 3, 4, 11, 4, 2, 7, 6);
        chk("t5_pump_lit", 32'(pump_width), 32'd9);
        chk("t5_mw2_lit", 32'(pio2_2_width), 32'd4);
        chk("t5_err_lit", 32'(seq_error), 32'd0);
        chk("t5_count_lit", 32'(cycle_count), 32'd6);

        // Stray MW pulse overlapping the first pump sample
        drive(1'b0, 1'b1, 1'b0, 3);
`ifdef POPMON_OVERLAP_CHECK_EN
        eq.push_back(cyc + 2);
`endif
        drive(1'b1, 1'b1, 1'b0, 1);
        drive(1'b1, 1'b0, 1'b0, 11);
        drive(1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 5);
        drive(1'b0, 1'b1, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b1, 4);
`ifndef POPMON_OVERLAP_CHECK_EN
        mq.push_back('{at: cyc + 3, pw: 12, m1: 2, fp: 5, m2: 2, prw: 4});
`endif
        drive(1'b0, 1'b0, 1'b0, 6);
`ifdef POPMON_OVERLAP_CHECK_EN
        chk("t6_err_lit", 32'(seq_error), 32'd1);
        chk("t6_count_lit", 32'(cycle_count), 32'd6);
`else
        chk("t6_err_lit", 32'(seq_error), 32'd0);
        chk("t6_count_lit", 32'(cycle_count), 32'd7);
`endif

        // Reset in the middle of a cycle, then a clean sequence
        drive(1'b1, 1'b0, 1'b0, 5);
        drive(1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 1'b0, 2);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3);
        chk("t7_rst_count_lit", 32'(cycle_count), 32'd0);
        chk("t7_rst_pump_lit", 32'(pump_width), 32'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2);
        run_seq(6, 2, 3, 5, 3, 2, 4, 5);
        chk("t7_count_lit", 32'(cycle_count), 32'd1);
        chk("t7_pump_lit", 32'(pump_width), 32'd6);
        chk("t7_err_lit", 32'(seq_error), 32'd0);

        drive(1'b0, 1'b0, 1'b0, 5);
        chk("meas_queue_drained", 32'(mq.size()), 32'd0);
        chk("err_queue_drained", 32'(eq.size()), 32'd0);
        chk("clr_queue_drained", 32'(cq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
